// File: rtl/bf_arith_coalescer.sv
// Folds runs of '+'/'-' into one signed delta pulse and forwards other BF commands; drops comments.
// Delta and forwarded op appear the cycle after the terminating edge; input stalls only while an op awaits i_op_out_ready.
module bf_arith_coalescer #(
    parameter int P_DELTA_W = 16,
    parameter int P_MAX_RUN = 255
) (
    input  logic                 i_clk,
    input  logic                 i_n_rst,
    input  logic                 i_op_valid,
    input  logic [7:0]           i_op,
    output logic                 o_op_ready,
    input  logic                 i_flush,
    output logic [P_DELTA_W-1:0] o_increment,
    output logic                 o_inc_valid,
    output logic                 o_op_out_valid,
    output logic [7:0]           o_op_out,
    input  logic                 i_op_out_ready
);

    localparam int CW = $clog2(P_MAX_RUN + 1);
    localparam logic signed [P_DELTA_W-1:0] ONE   = P_DELTA_W'(1);
    localparam logic        [CW-1:0]        MAX_C = CW'(P_MAX_RUN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EMIT_OP = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic signed [P_DELTA_W-1:0] delta_q, delta_d;
    logic        [CW-1:0]        count_q, count_d;
    logic        [P_DELTA_W-1:0] inc_q, inc_d;
    logic                        inc_vld_q, inc_vld_d;
    logic        [7:0]           op_out_q, op_out_d;
    logic                        op_vld_q, op_vld_d;

    logic                        op_ready;
    logic                        is_plus, is_minus, is_cmd;
    logic                        acc_arith, acc_cmd;
    logic signed [P_DELTA_W-1:0] delta_nxt, flush_val;
    logic        [CW-1:0]        count_nxt;
    logic                        run_full, do_flush;

    always_comb begin
        is_plus  = (i_op == 8'h2B);
        is_minus = (i_op == 8'h2D);
        case (i_op)
            8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: is_cmd = 1'b1;
            default:                                 is_cmd = 1'b0;
        endcase
        acc_arith = i_op_valid && op_ready && (is_plus || is_minus);
        acc_cmd   = i_op_valid && op_ready && is_cmd;
        delta_nxt = is_minus ? (delta_q - ONE) : (delta_q + ONE);
        count_nxt = count_q + CW'(1);
        run_full  = acc_arith && (count_nxt == MAX_C);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc_cmd)                    state_d = EMIT_OP;
                else if (acc_arith && !run_full) state_d = RUN;
            end
            RUN: begin
                if (acc_cmd)                   state_d = EMIT_OP;
                else if (i_flush || run_full)  state_d = IDLE;
            end
            EMIT_OP: begin
                if (i_op_out_ready)            state_d = IDLE;
            end
            default:                           state_d = IDLE;
        endcase
    end

    // Output decode: input is only stalled while a forwarded op is outstanding
    always_comb begin
        op_ready = (state_q != EMIT_OP);
    end

    // A run ends on a command, a flush, or the ARITH that fills it; that ARITH is part of the delta
    always_comb begin
        do_flush  = ((state_q == RUN) && (acc_cmd || i_flush || run_full)) ||
                    ((state_q == IDLE) && run_full);
        flush_val = acc_arith ? delta_nxt : delta_q;

        delta_d = delta_q;
        count_d = count_q;
        if (do_flush) begin
            delta_d = '0;
            count_d = '0;
        end else if (acc_arith) begin
            delta_d = delta_nxt;
            count_d = count_nxt;
        end

        inc_d     = '0;
        inc_vld_d = 1'b0;
        if (do_flush && (flush_val != '0)) begin
            inc_d     = flush_val;
            inc_vld_d = 1'b1;
        end

        op_out_d = op_out_q;
        op_vld_d = op_vld_q;
        if (acc_cmd) begin
            op_out_d = i_op;
            op_vld_d = 1'b1;
        end else if ((state_q == EMIT_OP) && i_op_out_ready) begin
            op_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            delta_q   <= '0;
            count_q   <= '0;
            inc_q     <= '0;
            inc_vld_q <= 1'b0;
            op_out_q  <= '0;
            op_vld_q  <= 1'b0;
        end else begin
            delta_q   <= delta_d;
            count_q   <= count_d;
            inc_q     <= inc_d;
            inc_vld_q <= inc_vld_d;
            op_out_q  <= op_out_d;
            op_vld_q  <= op_vld_d;
        end
    end

    assign o_op_ready     = op_ready;
    assign o_increment    = inc_q;
    assign o_inc_valid    = inc_vld_q;
    assign o_op_out       = op_out_q;
    assign o_op_out_valid = op_vld_q;

endmodule

// File: tb/tb_bf_arith_coalescer.sv
// Directed bench for bf_arith_coalescer with hand-computed expectations.
module tb_bf_arith_coalescer;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [7:0]  op;
    logic        op_ready;
    logic        flush;
    logic [15:0] increment;
    logic        inc_valid;
    logic        op_out_valid;
    logic [7:0]  op_out;
    logic        op_out_ready;

    int tests = 0;
    int fails = 0;

    bf_arith_coalescer #(.P_DELTA_W(16), .P_MAX_RUN(255)) dut (
        .i_clk          (clk),
        .i_n_rst        (rst_n),
        .i_op_valid     (op_valid),
        .i_op           (op),
        .o_op_ready     (op_ready),
        .i_flush        (flush),
        .o_increment    (increment),
        .o_inc_valid    (inc_valid),
        .o_op_out_valid (op_out_valid),
        .o_op_out       (op_out),
        .i_op_out_ready (op_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ch);
        op_valid = 1'b1;
        op       = ch;
        tick();
        op_valid = 1'b0;
        op       = 8'h00;
    endtask

    initial begin
        int   pulses;
        int   stalls;
        int   unstable;
        logic [15:0] seen;
        logic [7:0] s5 [7];

        rst_n = 1'b0; op_valid = 1'b0; op = 8'h00; flush = 1'b0; op_out_ready = 1'b1;
        #2;
        chk("rst_increment", {16'h0, increment}, 32'h0);
        chk("rst_inc_valid", {31'h0, inc_valid}, 32'h0);
        chk("rst_op_out_valid", {31'h0, op_out_valid}, 32'h0);
        chk("rst_op_out", {24'h0, op_out}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_op_ready", {31'h0, op_ready}, 32'h1);

        // "+++." with downstream ready
        send(8'h2B); send(8'h2B); send(8'h2B);
        chk("t1_no_early_pulse", {31'h0, inc_valid}, 32'h0);
        send(8'h2E);
        chk("t1_increment", {16'h0, increment}, 32'h3);
        chk("t1_inc_valid", {31'h0, inc_valid}, 32'h1);
        chk("t1_op_out_valid", {31'h0, op_out_valid}, 32'h1);
        chk("t1_op_out", {24'h0, op_out}, 32'h2E);
        chk("t1_op_ready_emit", {31'h0, op_ready}, 32'h0);
        tick();
        chk("t1_increment_after", {16'h0, increment}, 32'h0);
        chk("t1_inc_valid_after", {31'h0, inc_valid}, 32'h0);
        chk("t1_op_out_valid_after", {31'h0, op_out_valid}, 32'h0);
        chk("t1_op_ready_after", {31'h0, op_ready}, 32'h1);

        // "--+" then flush -> -1
        send(8'h2D); send(8'h2D); send(8'h2B);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t2_increment", {16'h0, increment}, 32'hFFFF);
        chk("t2_inc_valid", {31'h0, inc_valid}, 32'h1);
        chk("t2_op_out_valid", {31'h0, op_out_valid}, 32'h0);
        tick();
        chk("t2_inc_valid_after", {31'h0, inc_valid}, 32'h0);
        chk("t2_increment_after", {16'h0, increment}, 32'h0);
        // flush in IDLE is a no-op
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t2_idle_flush_nopulse", {31'h0, inc_valid}, 32'h0);

        // "+-+-" then '>' -> zero net, no pulse
        send(8'h2B); send(8'h2D); send(8'h2B); send(8'h2D);
        send(8'h3E);
        chk("t3_inc_valid", {31'h0, inc_valid}, 32'h0);
        chk("t3_increment", {16'h0, increment}, 32'h0);
        chk("t3_op_out_valid", {31'h0, op_out_valid}, 32'h1);
        chk("t3_op_out", {24'h0, op_out}, 32'h3E);
        tick();

        // 300 '+' -> saturating pulse at 255, remainder 45 on flush
        pulses = 0; stalls = 0; seen = 16'h0;
        for (int i = 1; i <= 300; i++) begin
            if (op_ready !== 1'b1) stalls++;
            send(8'h2B);
            if (inc_valid === 1'b1) begin
                pulses++;
                seen = increment;
            end
            if (i == 255) begin
                chk("t4_pulse255_valid", {31'h0, inc_valid}, 32'h1);
                chk("t4_pulse255_value", {16'h0, increment}, 32'h00FF);
            end
        end
        chk("t4_pulse_count", pulses, 32'd1);
        chk("t4_pulse_seen", {16'h0, seen}, 32'h00FF);
        chk("t4_no_stall", stalls, 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t4_tail_valid", {31'h0, inc_valid}, 32'h1);
        chk("t4_tail_value", {16'h0, increment}, 32'h002D);
        tick();

        // "+a+\n+ +" then flush -> 4, comments never stall
        s5[0] = 8'h2B; s5[1] = 8'h61; s5[2] = 8'h2B; s5[3] = 8'h0A;
        s5[4] = 8'h2B; s5[5] = 8'h20; s5[6] = 8'h2B;
        pulses = 0; stalls = 0;
        for (int i = 0; i < 7; i++) begin
            if (op_ready !== 1'b1) stalls++;
            send(s5[i]);
            if (inc_valid === 1'b1 || op_out_valid === 1'b1) pulses++;
        end
        chk("t5_no_early_output", pulses, 32'd0);
        chk("t5_no_stall", stalls, 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t5_valid", {31'h0, inc_valid}, 32'h1);
        chk("t5_value", {16'h0, increment}, 32'h0004);
        tick();

        // "++[" with downstream stalled for 5 cycles
        op_out_ready = 1'b0;
        send(8'h2B); send(8'h2B); send(8'h5B);
        chk("t6_pulse_valid", {31'h0, inc_valid}, 32'h1);
        chk("t6_pulse_value", {16'h0, increment}, 32'h0002);
        chk("t6_op_out", {24'h0, op_out}, 32'h5B);
        chk("t6_op_ready", {31'h0, op_ready}, 32'h0);
        unstable = 0; pulses = 0;
        op_valid = 1'b1; op = 8'h2B; flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (op_out !== 8'h5B || op_out_valid !== 1'b1 || op_ready !== 1'b0) unstable++;
            if (inc_valid === 1'b1) pulses++;
        end
        op_valid = 1'b0; op = 8'h00; flush = 1'b0;
        chk("t6_held_stable", unstable, 32'd0);
        chk("t6_no_pulse_while_held", pulses, 32'd0);
        op_out_ready = 1'b1;
        tick();
        chk("t6_released_valid", {31'h0, op_out_valid}, 32'h0);
        chk("t6_released_ready", {31'h0, op_ready}, 32'h1);
        // blocked '+' must not have leaked into a new run
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t6_no_leaked_arith", {31'h0, inc_valid}, 32'h0);

        // reset mid-run discards pending delta
        send(8'h2B); send(8'h2B);
        rst_n = 1'b0;
        #2;
        chk("t7_rst_increment", {16'h0, increment}, 32'h0);
        chk("t7_rst_inc_valid", {31'h0, inc_valid}, 32'h0);
        chk("t7_rst_op_out_valid", {31'h0, op_out_valid}, 32'h0);
        chk("t7_rst_op_out", {24'h0, op_out}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t7_no_pulse_after", {31'h0, inc_valid}, 32'h0);
        chk("t7_increment_after", {16'h0, increment}, 32'h0);
        chk("t7_op_ready_after", {31'h0, op_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
